// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared constants, FSM state type and byte-merge helper for
//               the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam int         DEPTH   = 2046;
  localparam logic [3:0] BE_FULL = 4'hF;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RMW  = 1'b1
  } state_t;

  // Byte i of the result comes from new_word when be[i] is set, else old_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] w_res;
    w_res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) w_res[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return w_res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bundles the IF port, LSU port and ram-side signals of the
//               data-memory arbiter. master = pipeline/memory side,
//               slave = arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  // Instruction fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  // Load/store port
  logic              ls_req;
  logic              ls_we;
  logic [3:0]        ls_be;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  // Memory side
  logic              ram_re;
  logic              ram_we;
  logic [31:0]       ram_raddr;
  logic [31:0]       ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  ram_re, ram_we, ram_raddr, ram_waddr, ram_wdata,
    output ram_rdata
  );

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output ram_re, ram_we, ram_raddr, ram_waddr, ram_wdata,
    input  ram_rdata
  );

endinterface

`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-request round-robin arbiter. Request 0 = IF, 1 = LSU.
//               On a tie the requester not granted last time wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       i_en,
  input  wire logic [1:0] i_req,
  output logic      [1:0] o_gnt
);

  logic r_last_ls;

  // Grant selection; nothing is granted while disabled.
  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      unique case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = r_last_ls ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  // Remember which port received the most recent grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_ls <= 1'b0;
    end else if (|o_gnt) begin
      r_last_ls <= o_gnt[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-port word memory between instruction fetch
//               and the load/store unit. Registers read data and performs
//               partial-word stores as a two-cycle read-modify-write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = dmem_pkg::DEPTH
) (
  input wire logic     clk,
  input wire logic     rst_n,
  dmem_arbiter_if.slave bus
);

  state_t            r_state;
  logic              r_if_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_ls_rvalid;
  logic [DATA_W-1:0] r_ls_rdata;
  logic [DATA_W-1:0] r_old;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_be;
  logic [31:0]       r_waddr;

  logic [1:0]  w_gnt;
  logic        w_if_g;
  logic        w_ls_g;
  logic        w_ls_rd;
  logic [31:0] w_if_word;
  logic [31:0] w_ls_word;
  logic        w_if_oor;
  logic        w_ls_oor;
  logic        w_ls_full;
  logic        w_ls_part;
  logic        w_arb_en;

  // Word addresses and range checks; byte-offset bits drop out in the shift.
  assign w_if_word = 32'(bus.if_addr[ADDR_W-1:0] >> 2);
  assign w_ls_word = 32'(bus.ls_addr[ADDR_W-1:0] >> 2);
  assign w_if_oor  = (w_if_word >= 32'(DEPTH));
  assign w_ls_oor  = (w_ls_word >= 32'(DEPTH));
  assign w_ls_full = (bus.ls_be == BE_FULL);
  assign w_ls_part = (bus.ls_be != BE_FULL) && (bus.ls_be != 4'h0);

  // Grants are blocked during the RMW write cycle and while reset is held,
  // so every output reads zero as soon as reset asserts.
  assign w_arb_en = (r_state == S_IDLE) && rst_n;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_arb_en),
    .i_req ({bus.ls_req, bus.if_req}),
    .o_gnt (w_gnt)
  );

  assign w_if_g  = w_gnt[0];
  assign w_ls_g  = w_gnt[1];
  assign w_ls_rd = w_ls_g && !bus.ls_we;

  assign bus.if_gnt    = w_if_g;
  assign bus.ls_gnt    = w_ls_g;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.ls_rvalid = r_ls_rvalid;
  assign bus.ls_rdata  = r_ls_rdata;

  // Memory strobes: RMW write-back takes priority, otherwise serve the grant.
  always_comb begin
    bus.ram_re    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_raddr = 32'h0;
    bus.ram_waddr = 32'h0;
    bus.ram_wdata = '0;
    if (r_state == S_RMW) begin
      bus.ram_we    = 1'b1;
      bus.ram_waddr = r_waddr;
      bus.ram_wdata = merge_bytes(r_old, r_wdata, r_be);
    end else if (w_if_g) begin
      bus.ram_re    = !w_if_oor;
      bus.ram_raddr = w_if_word;
    end else if (w_ls_g) begin
      if (!bus.ls_we) begin
        bus.ram_re    = !w_ls_oor;
        bus.ram_raddr = w_ls_word;
      end else if (!w_ls_oor) begin
        if (w_ls_full) begin
          bus.ram_we    = 1'b1;
          bus.ram_waddr = w_ls_word;
          bus.ram_wdata = bus.ls_wdata;
        end else if (w_ls_part) begin
          bus.ram_re    = 1'b1;
          bus.ram_raddr = w_ls_word;
        end
      end
    end
  end

  // Sequencer: read-data capture, rvalid pulses and the IDLE/RMW state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rvalid <= 1'b0;
      r_ls_rdata  <= '0;
      r_old       <= '0;
      r_wdata     <= '0;
      r_be        <= 4'h0;
      r_waddr     <= 32'h0;
    end else begin
      r_if_rvalid <= w_if_g;
      r_ls_rvalid <= w_ls_rd;
      if (w_if_g) r_if_rdata <= w_if_oor ? '0 : bus.ram_rdata;
      if (w_ls_rd) r_ls_rdata <= w_ls_oor ? '0 : bus.ram_rdata;
      unique case (r_state)
        S_IDLE: begin
          if (w_ls_g && bus.ls_we && w_ls_part && !w_ls_oor) begin
            r_old   <= bus.ram_rdata;
            r_wdata <= bus.ls_wdata;
            r_be    <= bus.ls_be;
            r_waddr <= w_ls_word;
            r_state <= S_RMW;
          end
        end
        S_RMW:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a simple
//               combinational-read word memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   wr_cnt;
  int   wr_snap;

  logic [31:0] mem [0:2045];

  dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(2046)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write at the clock edge.
  assign bus.ram_rdata = (bus.ram_raddr < 32'd2046) ? mem[bus.ram_raddr[10:0]] : 32'h0;

  always @(posedge clk) begin
    if (bus.ram_we) begin
      wr_cnt = wr_cnt + 1;
      if (bus.ram_waddr < 32'd2046) mem[bus.ram_waddr[10:0]] <= bus.ram_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    wr_cnt   = 0;
    for (int i = 0; i < 2046; i++) mem[i] = 32'h0;
    mem[2] = 32'h11223344;
    mem[4] = 32'hDEADBEEF;
    mem[5] = 32'h55555555;
    mem[6] = 32'h66666666;
    mem[7] = 32'h77777777;

    // Reset with a request already pending: outputs must stay quiet.
    rst_n        = 1'b0;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h10;
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.ls_be    = 4'h0;
    bus.ls_addr  = 32'h0;
    bus.ls_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_gnt", {31'b0, bus.if_gnt}, 32'd0);
    chk("rst_ram_re", {31'b0, bus.ram_re}, 32'd0);
    chk("rst_ram_we", {31'b0, bus.ram_we}, 32'd0);
    chk("rst_raddr", bus.ram_raddr, 32'h0);
    chk("rst_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Single IF read of word 4.
    chk("if_gnt", {31'b0, bus.if_gnt}, 32'd1);
    chk("if_raddr", bus.ram_raddr, 32'd4);
    chk("if_re", {31'b0, bus.ram_re}, 32'd1);
    step();
    bus.if_req = 1'b0;
    chk("if_rvalid", {31'b0, bus.if_rvalid}, 32'd1);
    chk("if_rdata", bus.if_rdata, 32'hDEADBEEF);
    chk("if_ls_rvalid", {31'b0, bus.ls_rvalid}, 32'd0);

    // Both ports loading continuously: LSU, IF, LSU, IF.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h14;
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_addr = 32'h18;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr_ls_gnt%0d", k), {31'b0, bus.ls_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr_if_gnt%0d", k), {31'b0, bus.if_gnt}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k > 0) begin
        chk($sformatf("rr_ls_rv%0d", k), {31'b0, bus.ls_rvalid}, (k % 2 == 1) ? 32'd1 : 32'd0);
        chk($sformatf("rr_if_rv%0d", k), {31'b0, bus.if_rvalid}, (k % 2 == 0) ? 32'd1 : 32'd0);
      end
      step();
    end
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    chk("rr_if_rv_last", {31'b0, bus.if_rvalid}, 32'd1);
    chk("rr_ls_rv_last", {31'b0, bus.ls_rvalid}, 32'd0);
    chk("rr_if_rdata", bus.if_rdata, 32'h55555555);
    chk("rr_ls_rdata", bus.ls_rdata, 32'h66666666);
    step();

    // Partial store to word 2 with IF contending.
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_be    = 4'b0101;
    bus.ls_addr  = 32'h8;
    bus.ls_wdata = 32'hAABBCCDD;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h10;
    #1;
    chk("rmw_ls_gnt", {31'b0, bus.ls_gnt}, 32'd1);
    chk("rmw_if_gnt0", {31'b0, bus.if_gnt}, 32'd0);
    chk("rmw_rd_re", {31'b0, bus.ram_re}, 32'd1);
    chk("rmw_rd_we", {31'b0, bus.ram_we}, 32'd0);
    chk("rmw_raddr", bus.ram_raddr, 32'd2);
    step();
    bus.ls_req = 1'b0;
    #1;
    chk("rmw_if_gnt1", {31'b0, bus.if_gnt}, 32'd0);
    chk("rmw_we", {31'b0, bus.ram_we}, 32'd1);
    chk("rmw_waddr", bus.ram_waddr, 32'd2);
    chk("rmw_wdata", bus.ram_wdata, 32'h11BB33DD);
    chk("rmw_no_rvalid", {31'b0, bus.ls_rvalid}, 32'd0);
    step();
    chk("rmw_if_after", {31'b0, bus.if_gnt}, 32'd1);
    chk("rmw_we_done", {31'b0, bus.ram_we}, 32'd0);
    step();
    bus.if_req = 1'b0;
    chk("rmw_mem2", mem[2], 32'h11BB33DD);
    chk("rmw_if_rdata", bus.if_rdata, 32'hDEADBEEF);

    // Full store then load of word 3.
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_be    = 4'hF;
    bus.ls_addr  = 32'h0C;
    bus.ls_wdata = 32'hCAFEF00D;
    #1;
    chk("fs_gnt", {31'b0, bus.ls_gnt}, 32'd1);
    chk("fs_we", {31'b0, bus.ram_we}, 32'd1);
    chk("fs_waddr", bus.ram_waddr, 32'd3);
    chk("fs_wdata", bus.ram_wdata, 32'hCAFEF00D);
    step();
    bus.ls_we = 1'b0;
    #1;
    chk("fs_ld_gnt", {31'b0, bus.ls_gnt}, 32'd1);
    chk("fs_ld_we", {31'b0, bus.ram_we}, 32'd0);
    chk("fs_no_rvalid", {31'b0, bus.ls_rvalid}, 32'd0);
    step();
    bus.ls_req = 1'b0;
    chk("fs_ld_rvalid", {31'b0, bus.ls_rvalid}, 32'd1);
    chk("fs_ld_rdata", bus.ls_rdata, 32'hCAFEF00D);
    step();

    // Out-of-range load and stores, plus a zero-enable store.
    wr_snap     = wr_cnt;
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_addr = 32'h2000;
    #1;
    chk("oor_ld_gnt", {31'b0, bus.ls_gnt}, 32'd1);
    step();
    bus.ls_we    = 1'b1;
    bus.ls_be    = 4'hF;
    bus.ls_wdata = 32'h12345678;
    chk("oor_ld_rvalid", {31'b0, bus.ls_rvalid}, 32'd1);
    chk("oor_ld_rdata", bus.ls_rdata, 32'h0);
    #1;
    chk("oor_st_gnt", {31'b0, bus.ls_gnt}, 32'd1);
    chk("oor_st_we", {31'b0, bus.ram_we}, 32'd0);
    step();
    bus.ls_be = 4'b0011;
    #1;
    chk("oor_pst_gnt", {31'b0, bus.ls_gnt}, 32'd1);
    chk("oor_pst_re", {31'b0, bus.ram_re}, 32'd0);
    step();
    bus.ls_be   = 4'h0;
    bus.ls_addr = 32'h8;
    #1;
    chk("oor_pst_no_rmw", {31'b0, bus.ram_we}, 32'd0);
    chk("be0_gnt", {31'b0, bus.ls_gnt}, 32'd1);
    chk("be0_re", {31'b0, bus.ram_re}, 32'd0);
    step();
    bus.ls_req = 1'b0;
    chk("oor_wr_cnt", wr_cnt, wr_snap);
    chk("be0_mem2", mem[2], 32'h11BB33DD);

    // Reset during the RMW write cycle abandons the write.
    wr_snap      = wr_cnt;
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_be    = 4'b0001;
    bus.ls_addr  = 32'h1C;
    bus.ls_wdata = 32'h000000AA;
    #1;
    chk("rr_rst_gnt", {31'b0, bus.ls_gnt}, 32'd1);
    step();
    bus.ls_req = 1'b0;
    chk("rr_rst_pre_we", {31'b0, bus.ram_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rr_rst_we", {31'b0, bus.ram_we}, 32'd0);
    chk("rr_rst_waddr", bus.ram_waddr, 32'h0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk("rr_rst_wr_cnt", wr_cnt, wr_snap);
    chk("rr_rst_mem7", mem[7], 32'h77777777);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port word memory `ram`. It shares the memory between instruction fetch (IF, read-only) and the load/store unit (LSU, read/write with byte enables), and registers read data. Partial-word stores are done as read-modify-write (RMW). It sits between the pipeline's IF/MEM stages and the `ram` instance and drives all `ram` inputs.

## Interface
Parameters:
- `DATA_W`, 32: data width; must be 32 because byte enables are 4 bits.
- `ADDR_W`, 32: byte-address width on both requester ports.
- `DEPTH`, 2046: number of words in `ram`. Valid word addresses are 0..DEPTH-1.

Ports:
- Clocking and reset, fixed: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `if_req`  in  1  IF read request; held until `if_gnt`.
- `if_addr`  in  ADDR_W  IF byte address; bits [1:0] are ignored.
- `if_gnt`  out  1  single-cycle accept pulse.
- `if_rvalid`  out  1  pulses one cycle after an IF grant.
- `if_rdata`  out  DATA_W  read word; valid while `if_rvalid` is high.
- `ls_req`  in  1  LSU request; held until `ls_gnt`.
- `ls_we`  in  1  1 = store, 0 = load.
- `ls_be`  in  4  byte enables for stores; bit i enables byte i.
- `ls_addr`  in  ADDR_W  LSU byte address; bits [1:0] are ignored.
- `ls_wdata`  in  DATA_W  store data, byte-lane aligned.
- `ls_gnt`  out  1  single-cycle accept pulse.
- `ls_rvalid`  out  1  pulses one cycle after a load grant only.
- `ls_rdata`  out  DATA_W  load word.
- `ram_re`, `ram_we`  out  1  memory read and write strobes.
- `ram_raddr`, `ram_waddr`  out  32  word addresses (byte address >> 2).
- `ram_wdata`  out  DATA_W  write word.
- `ram_rdata`  in  DATA_W  combinational read data from `ram`.

## Operation
- FSM states:
  - IDLE: arbitration is allowed.
  - RMW: second cycle of a partial store; no grants are issued.
- Arbitration in IDLE:
  - If only one port requests, that port is granted.
  - If both request, round-robin via `last_ls`. The port not granted last time wins.
  - `last_ls` updates on every grant. Reset value is 0, so the LSU wins the first tie.
- Read grant (IF, or LSU with `ls_we=0`):
  - In the grant cycle: `ram_re=1` and `ram_raddr=addr[31:2]`.
  - `ram_rdata` is registered at the edge into the requester's rdata register.
  - That port's rvalid is 1 in the next cycle.
- Full store (`ls_be=4'hF`): in the grant cycle, `ram_we=1`, `ram_waddr=addr[31:2]`, `ram_wdata=ls_wdata`. No rvalid.
- Partial store (`ls_be` not 0 and not F):
  - Grant cycle: `ram_re=1`, and the old word is captured. `ls_wdata`, `ls_be` and the word address are also latched. FSM goes to RMW.
  - RMW cycle: `ram_we=1` with the merged word. Byte i = `ls_wdata` byte i if be[i], else the old byte i. FSM returns to IDLE.
- `ls_be=0` store: granted, with no memory access.
- Out of range (word address >= DEPTH):
  - Still granted.
  - Writes are suppressed: no `ram_we`, no RMW.
  - Reads return 32'h0 with the normal rvalid timing.
- `ram_we` and `ram_re` are never both driven by different requesters in the same cycle.
- Reset values: all gnt, rvalid and ram strobes = 0; `if_rdata`, `ls_rdata`, `ram_*addr`, `ram_wdata` = 0; state = IDLE; `last_ls` = 0.

## Timing
- Grant is combinational from req in IDLE; gnt is 0 in RMW.
- Read latency: rvalid exactly 1 cycle after gnt. Rdata holds until the next read by the same port.
- Full store: 1 cycle, and the arbiter is free the next cycle.
- Partial store: 2 cycles. The other port is blocked for the RMW cycle even if it is requesting.
- A requester may deassert req only after gnt. Back-to-back requests get gnt on consecutive IDLE cycles.
- Reset asserted mid-RMW: the write is abandoned, the FSM goes to IDLE, and no `ram_we` is issued after reset.
- Both ports requesting continuously: grants alternate IF/LSU. No port waits more than 2 grant slots, or 3 cycles if an RMW is in progress.

## Structure
- Package `dmem_pkg`:
  - `DEPTH` and `BE_FULL=4'hF`.
  - State enum `{S_IDLE, S_RMW}`.
  - Function `merge_bytes(old, new, be)`.
- Sub-module `rr_arb2`: 2-request round-robin arbiter with `last` pointer and enable input (low during RMW). Everything else stays in `dmem_arbiter`.

## Test plan
- After reset, `if_req=1`, `if_addr=0x10`, mem[4]=0xDEADBEEF → `if_gnt` same cycle, `ram_raddr=4`; `if_rvalid=1` and `if_rdata=0xDEADBEEF` next cycle.
- Both req held for 4 grants, LSU loads → grant order LSU, IF, LSU, IF; each rvalid is on its own port only.
- mem[2]=0x11223344, store addr 0x8, be=4'b0101, wdata=0xAABBCCDD → 2 cycles; `ram_we` in the second cycle with 0x11BB33DD; `if_gnt` held 0 during RMW.
- Full store 0x0C = 0xCAFEF00D then LSU load 0x0C → single-cycle `ram_we`, load returns 0xCAFEF00D.
- LSU load addr 0x2000 (word 2048 ≥ DEPTH) → granted, `ls_rdata=0`; store to the same address → no `ram_we`.
- `rst_n` low during the RMW cycle → all outputs 0 immediately, no `ram_we` after release, target word unchanged.
